mem_bank_onehot: RTL

Parametrised single-clock register-file memory: the next generation of the team's 16-bit × 8-word memory with one-hot word select lines. Adds parametrised width and depth, per-byte write enables, a registered read port with valid strobe, selectable read-during-write mode, illegal-select detection and a self-timed bulk clear engine. It sits between the datapath controllers and the board-level test fixtures as the common scratch store.

---
 rtl/mem_bank_onehot.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bank_onehot.sv
// mem_bank_onehot
// ---------------------------------------------------------------------------
// Parametrised single-clock register-file scratch store with one-hot word
// select, per-byte write enables, a registered read port with valid strobe,
// selectable read-during-write behaviour, illegal-select detection and a
// self-timed bulk clear engine.
//
// Parameters:
//   DATA_W  - data width in bits (multiple of 8, 8..64)
//   DEPTH   - number of words / width of the one-hot select bus (2..64)
//   RD_MODE - same-word read-during-write: 0 = old data, 1 = merged new data
//   CLR_VAL - value loaded into every word by reset and by the clear engine
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   data    in   write data
//   addr    in   one-hot word select (bit i selects word i)
//   WEn     in   write request
//   be      in   byte-lane write enables (bit k covers data[8k+7:8k])
//   RE      in   read request
//   clr     in   start bulk clear
//   qout    out  registered read data
//   qvalid  out  one-cycle strobe, qout updated by a read on the last edge
//   busy    out  clear engine running, accesses ignored
//   sel_err out  one-cycle strobe, previous access had an illegal select
// ---------------------------------------------------------------------------
module mem_bank_onehot #(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       DEPTH   = 8,
  parameter int unsigned       RD_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data,
  input  logic [DEPTH-1:0]    addr,
  input  logic                WEn,
  input  logic [DATA_W/8-1:0] be,
  input  logic                RE,
  input  logic                clr,
  output logic [DATA_W-1:0]   qout,
  output logic                qvalid,
  output logic                busy,
  output logic                sel_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // True when exactly one select bit is set.
  function automatic logic is_onehot(input logic [DEPTH-1:0] s);
    logic [DEPTH-1:0] low_cleared;
    low_cleared = s & (s - DEPTH'(1));
    return (s != '0) && (low_cleared == '0);
  endfunction

  // Binary index of a one-hot select. Only meaningful for legal selects;
  // an illegal select is never used to address the array.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [DEPTH-1:0] s);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (s[i]) begin
        idx = idx | IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Byte-lane merge: lanes with enable set take new data, others keep old.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     lane_en
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < int'(NB); k++) begin
      if (lane_en[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] qout_q, qout_d;
  logic              qvalid_q, qvalid_d;
  logic              sel_err_q, sel_err_d;

  // Decoded access signals
  logic              legal_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] cur_word_s;
  logic [DATA_W-1:0] merged_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              acc_ok_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              clr_we_s;
  logic              last_ptr_s;

  assign legal_s    = is_onehot(addr);
  assign idx_s      = onehot_idx(addr);
  assign cur_word_s = mem_q[idx_s];
  assign merged_s   = merge_lanes(cur_word_s, data, be);

  // Accesses are only honoured in IDLE and never on the cycle that starts
  // a clear; everything else is dropped silently (no sel_err, no qvalid).
  assign acc_ok_s   = (state_q == ST_IDLE) && !clr;
  assign wr_en_s    = acc_ok_s && WEn && legal_s;
  assign rd_en_s    = acc_ok_s && RE && legal_s;
  assign clr_we_s   = (state_q == ST_CLEAR);
  assign last_ptr_s = (ptr_q == IDX_W'(DEPTH - 1));

  // With a simultaneous write, write-first mode returns the merged word.
  assign rd_word_s  = ((RD_MODE == 1) && WEn) ? merged_s : cur_word_s;

  // Next-state logic for the clear FSM and clear pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (last_ptr_s) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          state_d = ST_CLEAR;
          ptr_d   = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Next values for the registered read port and error strobe.
  always_comb begin
    qvalid_d  = rd_en_s;
    sel_err_d = acc_ok_s && (WEn || RE) && !legal_s;
    if (rd_en_s) begin
      qout_d = rd_word_s;
    end else begin
      qout_d = qout_q;
    end
  end

  // FSM, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      qout_q    <= '0;
      qvalid_q  <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      qout_q    <= qout_d;
      qvalid_q  <= qvalid_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Storage array: reset fill, clear-engine writes and byte-lane writes.
  // Clear writes and user writes are mutually exclusive by state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= CLR_VAL;
      end
    end else if (clr_we_s) begin
      mem_q[ptr_q] <= CLR_VAL;
    end else if (wr_en_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  assign qout    = qout_q;
  assign qvalid  = qvalid_q;
  assign busy    = (state_q == ST_CLEAR);
  assign sel_err = sel_err_q;

endmodule
